vcmp_mask_packer: RTL and testbench

Mask packer for the vector ALU. It sits directly downstream of the add/min/max/compare pipeline and consumes the per-element compare result bits that the pipeline produces for vmseq/vmsne/vmslt/vmsle/vmsgt-class ops. It packs those bits densely, one bit per element, into 64-bit mask-register words. Each completed word is emitted with a bit-enable and a destination word address for the register-file write port.

---
 rtl/vcmp_mask_packer.sv | 149 ++++++++++++++
 tb/tb_vcmp_mask_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vcmp_mask_packer.sv
// vcmp_mask_packer: packs per-element compare bits from the vector ALU into
// dense 64-bit mask-register words. Each emitted word carries a per-bit write
// enable and a destination word address.
module vcmp_mask_packer #(
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int SEW_WIDTH      = 2,
  parameter int MASK_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_cmp,
  input  logic [SEW_WIDTH-1:0]      in_sew,
  input  logic                      in_start,
  input  logic                      in_last,
  input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
  output logic                      out_valid,
  output logic [MASK_WIDTH-1:0]     out_mask,
  output logic [MASK_WIDTH-1:0]     out_mask_en,
  output logic [REQ_ADDR_WIDTH-1:0] out_addr,
  output logic                      out_drop
);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                    state_reg, state_next;
  logic [63:0]               acc_reg, acc_next;
  logic [6:0]                ptr_reg, ptr_next;
  logic [SEW_WIDTH-1:0]      sew_reg, sew_next;
  logic [REQ_ADDR_WIDTH-1:0] addr_reg, addr_next;

  logic                      out_valid_reg, out_valid_next;
  logic [63:0]               out_mask_reg, out_mask_next;
  logic [63:0]               out_mask_en_reg, out_mask_en_next;
  logic [REQ_ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;
  logic                      out_drop_reg, out_drop_next;

  // Beat decode. A start beat uses its own element width and packs from bit 0
  // of a fresh word; a continuation beat uses the latched width and pointer.
  logic                      start_beat;
  logic                      accept;
  logic [SEW_WIDTH-1:0]      beat_sew;
  logic [6:0]                beat_n;
  logic [7:0]                beat_bits;
  logic [6:0]                base_ptr;
  logic [63:0]               base_acc;
  logic [63:0]               merged;
  logic [6:0]                fill;
  logic [63:0]               fill_en;
  logic                      word_full;
  logic [REQ_ADDR_WIDTH-1:0] word_addr;

  assign start_beat = in_valid & in_start;
  assign accept     = in_valid & (in_start | (state_reg == PACK));
  assign beat_sew   = start_beat ? in_sew : sew_reg;
  assign beat_n     = 7'd8 >> beat_sew;
  assign base_ptr   = start_beat ? 7'd0 : ptr_reg;
  assign base_acc   = start_beat ? 64'd0 : acc_reg;
  assign word_addr  = start_beat ? in_addr : addr_reg;
  assign fill       = base_ptr + beat_n;
  assign word_full  = (fill == 7'd64);
  assign merged     = base_acc | ({56'd0, beat_bits} << base_ptr);

  // Keep only the low N compare bits of the beat.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_beat_bits
      assign beat_bits[gi] = in_cmp[gi] & (7'(gi) < beat_n);
    end
  endgenerate

  // Enable for every bit below the fill level; all ones when the word is full.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_fill_en
      assign fill_en[gi] = (7'(gi) < fill);
    end
  endgenerate

  // Next-state and output computation; everything holds unless a beat is accepted.
  always_comb begin
    state_next       = state_reg;
    acc_next         = acc_reg;
    ptr_next         = ptr_reg;
    sew_next         = sew_reg;
    addr_next        = addr_reg;
    out_valid_next   = 1'b0;
    out_drop_next    = 1'b0;
    out_mask_next    = out_mask_reg;
    out_mask_en_next = out_mask_en_reg;
    out_addr_next    = out_addr_reg;

    if (accept) begin
      if (start_beat) begin
        sew_next      = in_sew;
        out_drop_next = (state_reg == PACK) && (ptr_reg != 7'd0);
      end
      if (word_full || in_last) begin
        out_valid_next   = 1'b1;
        out_mask_next    = merged;
        out_mask_en_next = fill_en;
        out_addr_next    = word_addr;
        acc_next         = 64'd0;
        ptr_next         = 7'd0;
        addr_next        = word_full
                           ? word_addr + {{(REQ_ADDR_WIDTH-1){1'b0}}, 1'b1}
                           : word_addr;
        state_next       = in_last ? IDLE : PACK;
      end else begin
        acc_next   = merged;
        ptr_next   = fill;
        addr_next  = word_addr;
        state_next = PACK;
      end
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      acc_reg         <= 64'd0;
      ptr_reg         <= 7'd0;
      sew_reg         <= '0;
      addr_reg        <= '0;
      out_valid_reg   <= 1'b0;
      out_mask_reg    <= 64'd0;
      out_mask_en_reg <= 64'd0;
      out_addr_reg    <= '0;
      out_drop_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      ptr_reg         <= ptr_next;
      sew_reg         <= sew_next;
      addr_reg        <= addr_next;
      out_valid_reg   <= out_valid_next;
      out_mask_reg    <= out_mask_next;
      out_mask_en_reg <= out_mask_en_next;
      out_addr_reg    <= out_addr_next;
      out_drop_reg    <= out_drop_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_mask    = out_mask_reg;
  assign out_mask_en = out_mask_en_reg;
  assign out_addr    = out_addr_reg;
  assign out_drop    = out_drop_reg;

endmodule

// File: tb/tb_vcmp_mask_packer.sv
// Self-checking bench for vcmp_mask_packer: directed scenarios followed by
// randomized instructions, checked against a bit-queue reference model.
module tb_vcmp_mask_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_cmp;
  logic [1:0]  in_sew;
  logic        in_start;
  logic        in_last;
  logic [31:0] in_addr;
  logic        out_valid;
  logic [63:0] out_mask;
  logic [63:0] out_mask_en;
  logic [31:0] out_addr;
  logic        out_drop;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bits of the open instruction, in element order.
  bit          pend[$];
  bit          m_active;
  logic [1:0]  m_sew;
  logic [31:0] m_addr;
  logic [63:0] h_mask, h_en;
  logic [31:0] h_addr;

  vcmp_mask_packer #(.REQ_ADDR_WIDTH(32), .SEW_WIDTH(2), .MASK_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmp(in_cmp), .in_sew(in_sew),
    .in_start(in_start), .in_last(in_last), .in_addr(in_addr),
    .out_valid(out_valid), .out_mask(out_mask), .out_mask_en(out_mask_en),
    .out_addr(out_addr), .out_drop(out_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_active = 1'b0;
    m_sew    = 2'd0;
    m_addr   = 32'd0;
    h_mask   = 64'd0;
    h_en     = 64'd0;
    h_addr   = 32'd0;
  endtask

  // Drive one cycle of input, advance the model, then check the registered outputs.
  task automatic step(input bit v, input logic [7:0] cmp, input logic [1:0] sew,
                      input bit st, input bit ls, input logic [31:0] addr);
    bit e_valid, e_drop;
    int n;
    int cnt;
    e_valid = 1'b0;
    e_drop  = 1'b0;
    in_valid = v; in_cmp = cmp; in_sew = sew; in_start = st; in_last = ls; in_addr = addr;

    if (v && st) begin
      if (m_active && pend.size() != 0) e_drop = 1'b1;
      pend.delete();
      m_active = 1'b1;
      m_sew    = sew;
      m_addr   = addr;
    end
    if (v && m_active) begin
      n = 8 >> m_sew;
      for (int i = 0; i < n; i++) pend.push_back(cmp[i]);
      if (pend.size() == 64 || ls) begin
        e_valid = 1'b1;
        cnt     = pend.size();
        h_mask  = 64'd0;
        h_en    = 64'd0;
        for (int i = 0; i < cnt; i++) begin
          h_mask[i] = pend[i];
          h_en[i]   = 1'b1;
        end
        h_addr = m_addr;
        pend.delete();
        if (cnt == 64) m_addr = m_addr + 32'd1;
      end
      if (ls) m_active = 1'b0;
    end

    @(posedge clk);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
    check("out_drop", {63'd0, out_drop}, {63'd0, e_drop});
    check("out_mask", out_mask, h_mask);
    check("out_mask_en", out_mask_en, h_en);
    check("out_addr", {32'd0, out_addr}, {32'd0, h_addr});
    if (out_valid)
      $display("word addr=0x%08h mask=0x%016h en=0x%016h", out_addr, out_mask, out_mask_en);
    if (out_drop)
      $display("drop of partial word at %0t", $time);
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), $urandom);
  endtask

  initial begin
    int n, nb;
    bit abandon;
    logic [1:0]  s;
    logic [31:0] a;

    in_valid = 0; in_cmp = 0; in_sew = 0; in_start = 0; in_last = 0; in_addr = 0;
    rst = 1'b0;
    model_reset();
    #12;
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_mask", out_mask, 64'd0);
    check("reset_en", out_mask_en, 64'd0);
    check("reset_addr", {32'd0, out_addr}, 64'd0);
    check("reset_drop", {63'd0, out_drop}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // SEW=8, walking one across eight beats.
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'(1 << i), 2'd0, i == 0, i == 7, 32'h10);
    check("tp1_mask", out_mask, 64'h8040201008040201);
    check("tp1_en", out_mask_en, 64'hFFFF_FFFF_FFFF_FFFF);
    check("tp1_addr", {32'd0, out_addr}, 64'h10);
    idle();

    // SEW=64, three single-bit beats.
    step(1'b1, 8'h01, 2'd3, 1'b1, 1'b0, 32'h5);
    step(1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 32'h0);
    step(1'b1, 8'h01, 2'd3, 1'b0, 1'b1, 32'h0);
    check("tp2_mask", out_mask, 64'h5);
    check("tp2_en", out_mask_en, 64'h7);
    idle();

    // SEW=16, 17 back-to-back beats spanning two words.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'h0F, 2'd1, i == 0, i == 16, 32'h20);
      if (i == 15) check("tp3_w1_addr", {32'd0, out_addr}, 64'h20);
    end
    check("tp3_w2_mask", out_mask, 64'hF);
    check("tp3_w2_addr", {32'd0, out_addr}, 64'h21);
    idle();

    // SEW=32, single start+last beat with junk in the upper compare bits.
    step(1'b1, 8'hFE, 2'd2, 1'b1, 1'b1, 32'h7);
    check("tp4_mask", out_mask, 64'h2);
    check("tp4_en", out_mask_en, 64'h3);
    idle();

    // Abandoned instruction followed by a new start.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 2'd0, i == 0, 1'b0, 32'h30);
    step(1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 32'h40);
    check("tp5_drop", {63'd0, out_drop}, 64'd1);
    step(1'b1, 8'hC3, 2'd0, 1'b0, 1'b1, 32'h0);
    check("tp5_mask", out_mask, 64'hC33C);
    check("tp5_addr", {32'd0, out_addr}, 64'h40);
    idle();

    // Stray continuation beat while idle is ignored.
    step(1'b1, 8'hFF, 2'd0, 1'b0, 1'b1, 32'h99);

    // Asynchronous reset in the middle of an instruction.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 2'd0, i == 0, 1'b0, 32'h50);
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("areset_valid", {63'd0, out_valid}, 64'd0);
    check("areset_mask", out_mask, 64'd0);
    check("areset_en", out_mask_en, 64'd0);
    check("areset_addr", {32'd0, out_addr}, 64'd0);
    check("areset_drop", {63'd0, out_drop}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 8'h5A, 2'd0, 1'b1, 1'b1, 32'h60);
    check("areset_new_en", out_mask_en, 64'hFF);
    idle();

    // Randomized instructions, including address wrap and abandoned partials.
    for (int k = 0; k < 60; k++) begin
      s  = 2'($urandom);
      n  = 8 >> s;
      nb = $urandom_range(1, 160 / n);
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      abandon = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 4) == 0) idle();
        step(1'b1, 8'($urandom), 2'($urandom), i == 0,
             (i == nb - 1) && !abandon, (i == 0) ? a : $urandom);
      end
      if (!abandon && $urandom_range(0, 3) == 0)
        step(1'b1, 8'($urandom), 2'($urandom), 1'b0, 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
